// File: rtl/baud_rate_gen_frac.sv
// Fractional-divisor UART baud tick generator with independent TX bit and RX
// oversample engines sharing one runtime-programmable divisor.
module baud_rate_gen_frac #(
  parameter int unsigned DIV_INT_W        = 16,
  parameter int unsigned DIV_FRAC_W       = 4,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned DEFAULT_DIV_INT  = 54,
  parameter int unsigned DEFAULT_DIV_FRAC = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [DIV_INT_W-1:0]          cfg_div_int,
  input  logic [DIV_FRAC_W-1:0]         cfg_div_frac,
  output logic                          cfg_err,
  input  logic                          rx_resync,
  output logic                          tx_en,
  output logic                          rx_en,
  output logic [$clog2(OVERSAMPLE)-1:0] rx_phase,
  output logic                          rx_sample
);

  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned CNT_W = DIV_INT_W + 1;
  localparam int unsigned SUM_W = DIV_FRAC_W + 1;

  typedef enum logic [1:0] {CFG_IDLE, CFG_PENDING, CFG_APPLIED} cfg_state_t;

  cfg_state_t             cfg_state;
  logic [DIV_INT_W-1:0]   div_int, pend_int;
  logic [DIV_FRAC_W-1:0]  div_frac, pend_frac;
  logic [CNT_W-1:0]       tx_cnt, rx_cnt;
  logic [DIV_FRAC_W-1:0]  tx_acc, rx_acc;
  logic                   tx_carry, rx_carry;
  logic [OS_W-1:0]        tx_os, rx_os;

  logic [CNT_W-1:0]       tx_last, rx_last;
  logic [SUM_W-1:0]       tx_sum, rx_sum;
  logic [OS_W-1:0]        tx_os_inc, rx_os_inc;
  logic                   tx_tick, rx_tick, tx_wrap, apply;

  // Tick detection: period is div_int plus the carry left by the previous tick.
  always_comb begin
    tx_last   = CNT_W'(div_int) + CNT_W'(tx_carry) - CNT_W'(1);
    rx_last   = CNT_W'(div_int) + CNT_W'(rx_carry) - CNT_W'(1);
    tx_tick   = enable && (tx_cnt == tx_last);
    rx_tick   = enable && (rx_cnt == rx_last);
    tx_sum    = SUM_W'(tx_acc) + SUM_W'(div_frac);
    rx_sum    = SUM_W'(rx_acc) + SUM_W'(div_frac);
    tx_os_inc = tx_os + OS_W'(1);
    rx_os_inc = rx_os + OS_W'(1);
    tx_wrap   = tx_tick && (tx_os_inc == '0);
    apply     = (cfg_state == CFG_PENDING) && (!enable || tx_wrap);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_state <= CFG_IDLE;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      div_int   <= DIV_INT_W'(DEFAULT_DIV_INT);
      div_frac  <= DIV_FRAC_W'(DEFAULT_DIV_FRAC);
      pend_int  <= '0;
      pend_frac <= '0;
      tx_cnt    <= '0;
      tx_acc    <= '0;
      tx_carry  <= 1'b0;
      tx_os     <= '0;
      rx_cnt    <= '0;
      rx_acc    <= '0;
      rx_carry  <= 1'b0;
      rx_os     <= '0;
      tx_en     <= 1'b0;
      rx_en     <= 1'b0;
      rx_sample <= 1'b0;
      rx_phase  <= '0;
    end else begin
      rx_en     <= 1'b0;
      rx_sample <= 1'b0;
      cfg_err   <= 1'b0;
      tx_en     <= tx_wrap;

      // TX engine: only disable or a config apply restarts it.
      if (!enable || apply) begin
        tx_cnt   <= '0;
        tx_acc   <= '0;
        tx_carry <= 1'b0;
        tx_os    <= '0;
      end else if (tx_tick) begin
        tx_cnt              <= '0;
        {tx_carry, tx_acc}  <= tx_sum;
        tx_os               <= tx_os_inc;
      end else begin
        tx_cnt <= tx_cnt + CNT_W'(1);
      end

      // RX engine: a restart swallows any tick landing in the same cycle.
      if (!enable || apply || rx_resync) begin
        rx_cnt   <= '0;
        rx_acc   <= '0;
        rx_carry <= 1'b0;
        rx_os    <= '0;
        rx_phase <= '0;
      end else if (rx_tick) begin
        rx_cnt             <= '0;
        {rx_carry, rx_acc} <= rx_sum;
        rx_os              <= rx_os_inc;
        rx_en              <= 1'b1;
        rx_phase           <= rx_os_inc;
        rx_sample          <= (rx_os_inc == OS_W'(OVERSAMPLE / 2));
      end else begin
        rx_cnt <= rx_cnt + CNT_W'(1);
      end

      // Config handshake: hold a legal divisor until the next TX bit boundary.
      case (cfg_state)
        CFG_IDLE: begin
          if (cfg_valid) begin
            if (cfg_div_int < DIV_INT_W'(2)) begin
              cfg_err <= 1'b1;
            end else begin
              pend_int  <= cfg_div_int;
              pend_frac <= cfg_div_frac;
              cfg_ready <= 1'b0;
              cfg_state <= CFG_PENDING;
            end
          end
        end
        CFG_PENDING: begin
          if (apply) begin
            div_int   <= pend_int;
            div_frac  <= pend_frac;
            cfg_state <= CFG_APPLIED;
          end
        end
        CFG_APPLIED: begin
          cfg_ready <= 1'b1;
          cfg_state <= CFG_IDLE;
        end
        default: cfg_state <= CFG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_baud_rate_gen_frac.sv
// Bench for baud_rate_gen_frac: directed scenarios plus random traffic, all
// checked against a closed-form tick-time reference model.
module tb_baud_rate_gen_frac;

  localparam int OS       = 16;
  localparam int FRAC_DEN = 16;
  localparam int DEF_INT  = 4;
  localparam int DEF_FRAC = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_div_int = '0;
  logic [3:0]  cfg_div_frac = '0;
  logic        rx_resync = 1'b0;
  logic        cfg_ready, cfg_err, tx_en, rx_en, rx_sample;
  logic [3:0]  rx_phase;

  baud_rate_gen_frac #(
    .DIV_INT_W(16), .DIV_FRAC_W(4), .OVERSAMPLE(16),
    .DEFAULT_DIV_INT(DEF_INT), .DEFAULT_DIV_FRAC(DEF_FRAC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac),
    .cfg_err(cfg_err), .rx_resync(rx_resync),
    .tx_en(tx_en), .rx_en(rx_en), .rx_phase(rx_phase), .rx_sample(rx_sample)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  // Reference model: engine restarted at cycle s emits its k-th strobe at
  // s + k*I + floor((k-1)*F/16); tick k happens the cycle before.
  int     m_int = DEF_INT, m_frac = DEF_FRAC, p_int = 0, p_frac = 0, p_st = 0;
  longint tx_s = 0, rx_s = 0;
  int     k_tx = 0, k_rx = 0;
  bit     e_tx = 0, e_rx = 0, e_samp = 0, e_ready = 1, e_err = 0;
  int     e_phase = 0;

  logic [8:0] obs, expv;
  assign obs = {tx_en, rx_en, rx_sample, cfg_ready, cfg_err, rx_phase};
  always_comb expv = {e_tx, e_rx, e_samp, e_ready, e_err, 4'(e_phase)};

  function automatic longint tick_at(longint s, int k, int di, int df);
    return s + longint'(k + 1) * longint'(di) + longint'((k * df) / FRAC_DEN) - 1;
  endfunction

  task automatic model_step();
    longint t;
    bit wrap, apply;
    t = cyc;
    e_tx = 0; e_rx = 0; e_samp = 0; e_err = 0;
    wrap = 0; apply = 0;
    if (reset) begin
      m_int = DEF_INT; m_frac = DEF_FRAC; p_st = 0;
      tx_s = t + 1; rx_s = t + 1; k_tx = 0; k_rx = 0; e_phase = 0;
    end else begin
      if (enable && t == tick_at(tx_s, k_tx, m_int, m_frac)) begin
        k_tx++;
        if (k_tx % OS == 0) begin wrap = 1; e_tx = 1; end
      end
      apply = (p_st == 1) && (!enable || wrap);
      if (!enable) begin
        tx_s = t + 1; rx_s = t + 1; k_tx = 0; k_rx = 0; e_phase = 0;
      end else if (apply || rx_resync) begin
        rx_s = t + 1; k_rx = 0; e_phase = 0;
      end else if (t == tick_at(rx_s, k_rx, m_int, m_frac)) begin
        k_rx++;
        e_rx = 1;
        e_phase = k_rx % OS;
        e_samp = (e_phase == OS / 2);
      end
      case (p_st)
        0: if (cfg_valid) begin
             if (cfg_div_int < 2) e_err = 1;
             else begin p_int = int'(cfg_div_int); p_frac = int'(cfg_div_frac); p_st = 1; end
           end
        1: if (apply) begin
             m_int = p_int; m_frac = p_frac;
             tx_s = t + 1; rx_s = t + 1; k_tx = 0; k_rx = 0; e_phase = 0;
             p_st = 2;
           end
        default: p_st = 0;
      endcase
    end
    e_ready = (p_st == 0);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    reset = 1; enable = 0; cfg_valid = 0; rx_resync = 0;
    cycle();
    cycle();
    reset = 0; enable = 1;
  endtask

  task automatic test_reset();
    reset = 1; enable = 1; cfg_valid = 1; cfg_div_int = 16'd7;
    for (int r = 0; r < 3; r++) begin
      cycle();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, obs, expv); end
      checks++;
      if (obs !== 9'b000100000) begin errors++; $display("FAIL reset_values cyc=%0d got=%b exp=%b", cyc, obs, 9'b000100000); end
    end
    cfg_valid = 0;
  endtask

  task automatic test_cadence();
    longint c0;
    int rxq[$], txq[$];
    logic [3:0] ph8;
    apply_reset();
    c0 = cyc;
    ph8 = '0;
    for (int r = 0; r < 140; r++) begin
      cycle();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL cadence rel=%0d got=%b exp=%b", cyc - c0, obs, expv); end
      if (rx_en) rxq.push_back(int'(cyc - c0));
      if (tx_en) txq.push_back(int'(cyc - c0));
      if (cyc - c0 == 8) ph8 = rx_phase;
    end
    checks++;
    if (rxq.size() != 35 || rxq[0] != 4 || rxq[1] != 8 || rxq[2] != 12)
      begin errors++; $display("FAIL cadence_rx count=%0d (need 35, first 4,8,12)", rxq.size()); end
    checks++;
    if (txq.size() != 2 || txq[0] != 64 || txq[1] != 128)
      begin errors++; $display("FAIL cadence_tx count=%0d (need 2 at 64,128)", txq.size()); end
    checks++;
    if (ph8 !== 4'd2) begin errors++; $display("FAIL cadence_phase got=%0d exp=2", ph8); end
  endtask

  task automatic test_fraction();
    longint c0;
    int rxq[$];
    int want[7];
    int n;
    bit bad;
    want = '{4, 8, 13, 17, 22, 26, 31};
    apply_reset();
    enable = 0; cfg_valid = 1; cfg_div_int = 16'd4; cfg_div_frac = 4'd8;
    cycle();
    checks++;
    if (obs !== expv) begin errors++; $display("FAIL fraction_cfg cyc=%0d got=%b exp=%b", cyc, obs, expv); end
    cfg_valid = 0;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 10) begin
      cycle();
      n++;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL fraction_wait cyc=%0d got=%b exp=%b", cyc, obs, expv); end
    end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL fraction_ready_timeout got=%b exp=1", cfg_ready); end
    enable = 1;
    c0 = cyc;
    for (int r = 0; r < 1600; r++) begin
      cycle();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL fraction rel=%0d got=%b exp=%b", cyc - c0, obs, expv); end
      if (rx_en) rxq.push_back(int'(cyc - c0));
    end
    bad = (rxq.size() < 7);
    for (int i = 0; i < 7 && !bad; i++) if (rxq[i] != want[i]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL fraction_times first rx_en not 4,8,13,17,22,26,31 (count %0d)", rxq.size()); end
    checks++;
    if (rxq.size() < 355 || rxq.size() > 356)
      begin errors++; $display("FAIL fraction_count got=%0d exp=355..356", rxq.size()); end
  endtask

  task automatic test_resync();
    longint c0;
    bit rxh[0:80], smp[0:80], txh[0:80];
    bit any;
    int fs;
    apply_reset();
    c0 = cyc;
    for (int r = 0; r < 70; r++) begin
      rx_resync = (r == 30);
      cycle();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL resync rel=%0d got=%b exp=%b", cyc - c0, obs, expv); end
      rxh[r + 1] = rx_en; smp[r + 1] = rx_sample; txh[r + 1] = tx_en;
    end
    rx_resync = 0;
    any = 0;
    for (int i = 31; i <= 34; i++) any |= rxh[i];
    checks++;
    if (any || !rxh[28]) begin errors++; $display("FAIL resync_gap rx_en in 31..34=%0b, at 28=%0b (need 0,1)", any, rxh[28]); end
    checks++;
    if (!rxh[35]) begin errors++; $display("FAIL resync_first got=0 exp=1 at 35"); end
    fs = -1;
    for (int i = 31; i <= 70; i++) if (smp[i] && fs < 0) fs = i;
    checks++;
    if (fs != 63) begin errors++; $display("FAIL resync_sample got=%0d exp=63", fs); end
    checks++;
    if (!txh[64]) begin errors++; $display("FAIL resync_tx got=0 exp=1 at 64"); end
  endtask

  task automatic test_config_apply();
    longint c0;
    bit rxh[0:80], txh[0:80], rdy[0:80];
    int cnt;
    apply_reset();
    c0 = cyc;
    rdy[0] = cfg_ready;
    cfg_div_int = 16'd6; cfg_div_frac = 4'd0;
    for (int r = 0; r < 80; r++) begin
      cfg_valid = (r == 10);
      cycle();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL cfg_apply rel=%0d got=%b exp=%b", cyc - c0, obs, expv); end
      rxh[r + 1] = rx_en; txh[r + 1] = tx_en; rdy[r + 1] = cfg_ready;
    end
    cfg_valid = 0;
    checks++;
    if (!rdy[10] || rdy[11] || rdy[64] || !rdy[65])
      begin errors++; $display("FAIL cfg_ready_seq got=%0b%0b%0b%0b exp=1001 (cycles 10,11,64,65)", rdy[10], rdy[11], rdy[64], rdy[65]); end
    checks++;
    if (!txh[64]) begin errors++; $display("FAIL cfg_tx got=0 exp=1 at 64"); end
    cnt = 0;
    for (int i = 65; i <= 80; i++) cnt += int'(rxh[i]);
    checks++;
    if (!rxh[70] || !rxh[76] || cnt != 2)
      begin errors++; $display("FAIL cfg_rx got 70=%0b 76=%0b count=%0d exp 1,1,2", rxh[70], rxh[76], cnt); end
  endtask

  task automatic test_illegal_cfg();
    longint c0;
    bit rxh[0:20], err[0:20];
    bit rdy_ok;
    int nerr, nrx;
    apply_reset();
    c0 = cyc;
    rdy_ok = 1;
    cfg_div_int = 16'd1; cfg_div_frac = 4'd3;
    for (int r = 0; r < 20; r++) begin
      cfg_valid = (r == 5);
      cycle();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL illegal rel=%0d got=%b exp=%b", cyc - c0, obs, expv); end
      rxh[r + 1] = rx_en; err[r + 1] = cfg_err;
      if (cfg_ready !== 1'b1) rdy_ok = 0;
    end
    cfg_valid = 0;
    nerr = 0; nrx = 0;
    for (int i = 1; i <= 20; i++) begin nerr += int'(err[i]); nrx += int'(rxh[i]); end
    checks++;
    if (!err[6] || nerr != 1) begin errors++; $display("FAIL illegal_err at6=%0b count=%0d exp 1,1", err[6], nerr); end
    checks++;
    if (!rdy_ok) begin errors++; $display("FAIL illegal_ready got dropped exp=1 throughout"); end
    checks++;
    if (nrx != 5 || !rxh[8] || !rxh[20]) begin errors++; $display("FAIL illegal_cadence count=%0d exp=5", nrx); end
  endtask

  task automatic test_enable_reset();
    longint c0;
    bit rxh[0:40], txh[0:40];
    bit any, rdy_ok;
    apply_reset();
    c0 = cyc;
    for (int r = 0; r < 40; r++) begin
      enable = !(r >= 21 && r <= 25);
      cycle();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL enable rel=%0d got=%b exp=%b", cyc - c0, obs, expv); end
      rxh[r + 1] = rx_en; txh[r + 1] = tx_en;
    end
    any = 0;
    for (int i = 22; i <= 29; i++) any |= rxh[i] | txh[i];
    checks++;
    if (any || !rxh[30]) begin errors++; $display("FAIL enable_gap strobes in 22..29=%0b rx at 30=%0b exp 0,1", any, rxh[30]); end
    // Pending config thrown away by reset.
    enable = 1; cfg_valid = 1; cfg_div_int = 16'd9; cfg_div_frac = 4'd5;
    cycle();
    cfg_valid = 0;
    cycle();
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL pending_ready got=%b exp=0", cfg_ready); end
    apply_reset();
    c0 = cyc;
    rdy_ok = 1;
    for (int r = 0; r < 12; r++) begin
      cycle();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL reset_pending rel=%0d got=%b exp=%b", cyc - c0, obs, expv); end
      rxh[r + 1] = rx_en;
      if (cfg_ready !== 1'b1) rdy_ok = 0;
    end
    checks++;
    if (!rxh[4] || !rxh[8] || !rxh[12] || !rdy_ok)
      begin errors++; $display("FAIL reset_default rx 4,8,12=%0b%0b%0b ready=%0b exp 111,1", rxh[4], rxh[8], rxh[12], rdy_ok); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int r = 0; r < 4000; r++) begin
      reset        = ($urandom_range(0, 499) == 0);
      enable       = ($urandom_range(0, 59) != 0);
      rx_resync    = ($urandom_range(0, 39) == 0);
      cfg_valid    = ($urandom_range(0, 15) == 0);
      cfg_div_int  = 16'($urandom_range(0, 7));
      cfg_div_frac = 4'($urandom_range(0, 15));
      cycle();
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, expv); end
    end
    reset = 0; rx_resync = 0; cfg_valid = 0;
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_fraction();
    test_resync();
    test_config_apply();
    test_illegal_cfg();
    test_enable_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
